mem_access_unit: RTL
====================

# mem_access_unit

Load/store execution stage placed between the ALU memory-op output and the data-memory bus. Accepts one decoded memory operation at a time (effective address, store data, destination register, funct3, read/write flags), runs a request/acknowledge transaction on the word-wide data bus with byte-lane steering, and returns sign- or zero-extended load data to register writeback. Stores complete without writeback.

## Interface
Parameters:
- cXLEN, 32: data and address width; fixed at 32 for 4-lane steering.
- cRegAddrW, 5: destination register address width.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iMemValid  in  1  memory op offered.
- oMemReady  out  1  unit can accept an op this cycle.
- iMemAddr  in  cXLEN  effective byte address.
- iMemData  in  cXLEN  store data, right-aligned.
- iMemRdAddr  in  cRegAddrW  load destination register.
- iMemOpType  in  3  funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- iMemRead  in  1  op is a load.
- iMemWrite  in  1  op is a store.
- oBusReq  out  1  bus request; held until iBusAck.
- oBusWe  out  1  1 = write.
- oBusAddr  out  cXLEN  word address, bits [1:0] always 0.
- oBusWData  out  cXLEN  lane-replicated write data.
- oBusBe  out  4  byte enables; 0000 on reads.
- iBusAck  in  1  bus completes the request this cycle; iBusRData valid on reads.
- iBusRData  in  cXLEN  read word.
- oWbDv  out  1  one-cycle writeback strobe.
- oWbAddr  out  cRegAddrW  writeback register.
- oWbData  out  cXLEN  extended load result.
- oErr  out  1  one-cycle pulse: op rejected, no bus access made.

## Operation
- States: IDLE, REQ, RESP. oMemReady = (state == IDLE).
- IDLE: on iMemValid & oMemReady, register all op fields. If exactly one of iMemRead/iMemWrite is set and funct3 is legal for that direction (loads 000,001,010,100,101; stores 000,001,010), go REQ. Otherwise pulse oErr next cycle, stay IDLE (op consumed).
- REQ: oBusReq=1, all bus outputs stable from registered op. On iBusAck: store -> IDLE; load -> capture extracted data, go RESP.
- RESP: oWbDv=1 for exactly one cycle with oWbAddr/oWbData; -> IDLE. If oWbAddr==0, oWbDv stays 0 (x0 never written); state still passes through RESP.
- Store steering: SB be=0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{data[15:0]}}; SW be=1111, wdata=data.
- Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- Reset (anytime, incl. mid-transaction): state -> IDLE immediately; oBusReq, oBusWe, oBusBe, oWbDv, oErr, oBusAddr, oBusWData, oWbAddr, oWbData -> 0; oMemReady=0 while iRst high, 1 on first cycle after release. In-flight op discarded; an iBusAck arriving after reset is ignored.

## Timing
- Op accepted at edge N -> oBusReq high in cycle N+1. iBusAck may arrive in that same cycle (zero wait) or any later cycle; no timeout.
- Load: ack in cycle K -> oWbDv high in cycle K+1. Min load latency 2 cycles accept-to-writeback; min throughput 1 load per 3 cycles, 1 store per 2.
- oErr: op accepted at edge N -> oErr high in cycle N+1 only; oMemReady stays 1.
- iBusAck while not in REQ: ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=00 is rejected like an illegal op (oErr pulse, no bus access, no writeback).
- Undefined: no misalignment check; halfword ignores addr[0], word ignores addr[1:0] (access aligned down). oErr then only reports illegal funct3 / read-write flag combinations.

## Test plan
- SB addr=0x1003 data=0x000000A5, ack same cycle -> oBusAddr=0x1000, oBusBe=1000, oBusWData=0xA5A5A5A5, oBusWe=1, no oWbDv, ready again 2 cycles after accept.
- LB addr=0x2001 rd=5, rdata=0x1234F678 after 3 wait cycles -> oWbDv one cycle after ack, oWbAddr=5, oWbData=0xFFFFFFF6; LBU same -> 0x000000F6.
- LH addr=0x2002 rdata=0x8001_0000 -> 0xFFFF8001; LHU -> 0x00008001; LW rd=0 -> no oWbDv pulse.
- Illegal: funct3=011 load, and read=write=1 -> oErr single pulse each, oBusReq never asserted.
- LW addr=0x3002: with MEM_MISALIGN_TRAP_EN -> oErr, no bus req; without -> oBusAddr=0x3000, full-word writeback.
- Assert iRst during REQ with oBusReq high -> oBusReq drops asynchronously, later iBusAck ignored, no oWbDv, oMemReady=1 first cycle after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store stage: one memory op at a time, req/ack data bus, lane steering.
// Optional misalignment rejection under MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int cXLEN     = 32,
  parameter int cRegAddrW = 5
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iMemValid,
  output logic                 oMemReady,
  input  logic [cXLEN-1:0]     iMemAddr,
  input  logic [cXLEN-1:0]     iMemData,
  input  logic [cRegAddrW-1:0] iMemRdAddr,
  input  logic [2:0]           iMemOpType,
  input  logic                 iMemRead,
  input  logic                 iMemWrite,
  output logic                 oBusReq,
  output logic                 oBusWe,
  output logic [cXLEN-1:0]     oBusAddr,
  output logic [cXLEN-1:0]     oBusWData,
  output logic [3:0]           oBusBe,
  input  logic                 iBusAck,
  input  logic [cXLEN-1:0]     iBusRData,
  output logic                 oWbDv,
  output logic [cRegAddrW-1:0] oWbAddr,
  output logic [cXLEN-1:0]     oWbData,
  output logic                 oErr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state, stateNxt;

  logic             accept;
  logic             isLoad;
  logic             isStore;
  logic             legal;
  logic [3:0]       beNxt;
  logic [cXLEN-1:0] wdNxt;
  logic [1:0]       offQ;
  logic [2:0]       typeQ;
  logic [7:0]       byteSel;
  logic [15:0]      halfSel;
  logic [cXLEN-1:0] ldData;
  logic             errQ;

  assign oMemReady = (state == IDLE) & ~iRst;
  assign accept    = iMemValid & oMemReady;
  assign isLoad    = iMemRead & ~iMemWrite;
  assign isStore   = iMemWrite & ~iMemRead;
  assign oBusReq   = (state == REQ);
  assign oErr      = errQ;
  assign oWbDv     = (state == RESP) && (oWbAddr != '0);

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      isLoad:  legal = iMemOpType inside {3'b000, 3'b001, 3'b010,
                                          3'b100, 3'b101};
      isStore: legal = iMemOpType inside {3'b000, 3'b001, 3'b010};
      default: legal = 1'b0;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if (iMemOpType[1:0] == 2'b01 && iMemAddr[0])
      legal = 1'b0;
    if (iMemOpType[1:0] == 2'b10 && iMemAddr[1:0] != 2'b00)
      legal = 1'b0;
`endif
  end

  // Store lane steering; loads never assert byte enables.
  always_comb begin
    beNxt = 4'b0000;
    wdNxt = '0;
    if (isStore) begin
      unique case (iMemOpType[1:0])
        2'b00: begin
          beNxt = 4'b0001 << iMemAddr[1:0];
          wdNxt = {4{iMemData[7:0]}};
        end
        2'b01: begin
          beNxt = iMemAddr[1] ? 4'b1100 : 4'b0011;
          wdNxt = {2{iMemData[15:0]}};
        end
        default: begin
          beNxt = 4'b1111;
          wdNxt = iMemData;
        end
      endcase
    end
  end

  assign byteSel = iBusRData[{offQ, 3'b000} +: 8];
  assign halfSel = iBusRData[{offQ[1], 4'b0000} +: 16];

  always_comb begin
    unique case (typeQ)
      3'b000:  ldData = {{(cXLEN-8){byteSel[7]}}, byteSel};
      3'b001:  ldData = {{(cXLEN-16){halfSel[15]}}, halfSel};
      3'b100:  ldData = {{(cXLEN-8){1'b0}}, byteSel};
      3'b101:  ldData = {{(cXLEN-16){1'b0}}, halfSel};
      default: ldData = iBusRData;
    endcase
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: if (accept && legal) stateNxt = REQ;
      REQ:  if (iBusAck) stateNxt = oBusWe ? IDLE : RESP;
      RESP: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      state <= IDLE;
    else
      state <= stateNxt;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      errQ      <= 1'b0;
      oBusWe    <= 1'b0;
      oBusAddr  <= '0;
      oBusWData <= '0;
      oBusBe    <= 4'b0000;
      offQ      <= 2'b00;
      typeQ     <= 3'b000;
      oWbAddr   <= '0;
      oWbData   <= '0;
    end else begin
      errQ <= accept & ~legal;
      if (accept && legal) begin
        oBusWe    <= isStore;
        oBusAddr  <= {iMemAddr[cXLEN-1:2], 2'b00};
        oBusWData <= wdNxt;
        oBusBe    <= beNxt;
        offQ      <= iMemAddr[1:0];
        typeQ     <= iMemOpType;
        oWbAddr   <= iMemRdAddr;
      end
      if (state == REQ && iBusAck && !oBusWe)
        oWbData <= ldData;
    end
  end

endmodule
